// File: rtl/half_multiply_core.sv
// -----------------------------------------------------------------------------
// half_multiply_core
//
// Two-stage pipelined multiprecision multiplier that returns either the low or
// the high half of the product of two operands held in redundant form.
//
// Each operand is NUM_ELEMENTS words of DSP_BIT_LEN bits. Word k has weight
// 2^(k*WORD_LEN). The spare bit(s) above WORD_LEN let callers pass values that
// are not carry-normalised.
//
//   ctl = 0 : out = (VA*VB) mod 2^(WORD_LEN*NUM_ELEMENTS_OUT)
//   ctl = 1 : out = floor(VA*VB / 2^(WORD_LEN*NUM_ELEMENTS)) mod 2^(WORD_LEN*NUM_ELEMENTS_OUT)
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears every pipeline register
//   ctl    : half select, travels with its operands
//   A, B   : operands, NUM_ELEMENTS words each
//   out    : result, NUM_ELEMENTS_OUT words, carry-normalised (upper bits 0)
//
// Timing: A/B/ctl are captured on edge N, and out is valid after edge N+1.
// A new transaction can be accepted on every cycle.
// -----------------------------------------------------------------------------
module half_multiply_core #(
  parameter int NUM_ELEMENTS     = 3,
  parameter int DSP_BIT_LEN      = 17,
  parameter int WORD_LEN         = 16,
  parameter int NUM_ELEMENTS_OUT = NUM_ELEMENTS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ctl,
  input  logic [DSP_BIT_LEN-1:0] A   [NUM_ELEMENTS],
  input  logic [DSP_BIT_LEN-1:0] B   [NUM_ELEMENTS],
  output logic [DSP_BIT_LEN-1:0] out [NUM_ELEMENTS_OUT]
);

  // The column accumulator must hold NUM_ELEMENTS full-width partial products.
  // It must also hold the carry coming in from the column below. The extra
  // bits give headroom for that carry.
  localparam int ACC_W    = 2*DSP_BIT_LEN + $clog2(NUM_ELEMENTS) + 2;
  // Every column up to the top output word of the high half is needed. This
  // lets carries from the low columns ripple into the high half exactly.
  localparam int NUM_COLS = NUM_ELEMENTS + NUM_ELEMENTS_OUT;

  // Stage 1: operand and ctl registers
  logic [DSP_BIT_LEN-1:0] a_d [NUM_ELEMENTS];
  logic [DSP_BIT_LEN-1:0] a_q [NUM_ELEMENTS];
  logic [DSP_BIT_LEN-1:0] b_d [NUM_ELEMENTS];
  logic [DSP_BIT_LEN-1:0] b_q [NUM_ELEMENTS];
  logic                   ctl_d;
  logic                   ctl_q;

  // Stage 2: result register
  logic [DSP_BIT_LEN-1:0] out_d [NUM_ELEMENTS_OUT];
  logic [DSP_BIT_LEN-1:0] out_q [NUM_ELEMENTS_OUT];

  // Column arithmetic
  logic [ACC_W-1:0]    col_sum [NUM_COLS];
  logic [ACC_W-1:0]    carry;
  logic [WORD_LEN-1:0] digit   [NUM_COLS];

  always_comb begin
    a_d   = A;
    b_d   = B;
    ctl_d = ctl;
  end

  // Schoolbook multiply. Each column's partial products are summed together
  // with the carry from the column below. The low WORD_LEN bits of the sum
  // become that column's digit, and the rest becomes the carry into the next
  // column.
  always_comb begin
    // NOTE: every combinational variable gets a default before any conditional
    // assignment, so no path can leave a value held and infer a latch.
    carry = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      col_sum[c] = '0;
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        for (int j = 0; j < NUM_ELEMENTS; j++) begin
          if (i + j == c) begin
            col_sum[c] = col_sum[c] + ACC_W'(a_q[i]) * ACC_W'(b_q[j]);
          end
        end
      end
      col_sum[c] = col_sum[c] + carry;
      digit[c]   = col_sum[c][WORD_LEN-1:0];
      carry      = col_sum[c] >> WORD_LEN;
    end
    // The carry out of the top selected column is dropped, which is the
    // mod 2^(WORD_LEN*NUM_ELEMENTS_OUT).
    for (int k = 0; k < NUM_ELEMENTS_OUT; k++) begin
      out_d[k] = DSP_BIT_LEN'(ctl_q ? digit[NUM_ELEMENTS + k] : digit[k]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples its pre-edge value and the order of the statements does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these arrays are pipeline registers, not storage RAM. They are
      // cleared element by element so that reset discards in-flight work and
      // out reads 0.
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      ctl_q <= 1'b0;
      for (int k = 0; k < NUM_ELEMENTS_OUT; k++) begin
        out_q[k] <= '0;
      end
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      ctl_q <= ctl_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_half_multiply_core.sv
// -----------------------------------------------------------------------------
// tb_half_multiply_core
//
// Scoreboard bench for half_multiply_core using the default parameters
// (3 words of 17 bits, radix 2^16).
//
// The stimulus side pushes the expected 48-bit result of each transaction it
// issues. The expected value is computed from the operand values with plain
// wide arithmetic. A monitor on the falling edge pops one entry whenever a
// transaction is due at the output, and compares it.
// -----------------------------------------------------------------------------
module tb_half_multiply_core;

  localparam int NE   = 3;
  localparam int DW   = 17;
  localparam int WL   = 16;
  localparam int NEO  = NE;
  localparam int MW   = WL * NEO;   // 48-bit result window

  logic          clk;
  logic          rst_n;
  logic          ctl;
  logic [DW-1:0] a_in  [NE];
  logic [DW-1:0] b_in  [NE];
  logic [DW-1:0] out_w [NEO];

  half_multiply_core #(
    .NUM_ELEMENTS    (NE),
    .DSP_BIT_LEN     (DW),
    .WORD_LEN        (WL),
    .NUM_ELEMENTS_OUT(NEO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ctl  (ctl),
    .A    (a_in),
    .B    (b_in),
    .out  (out_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  logic [MW-1:0] sb_q [$];
  logic          issued;
  logic          v1;
  logic          v2;

  task automatic check(input string name, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%012h expected 0x%012h", name, got, exp);
    end
  endtask

  // Reference model: it builds the operand integers and multiplies them
  // exactly. It then takes the requested 48-bit half of the product.
  function automatic logic [MW-1:0] model(input logic [NE*DW-1:0] a_pk,
                                          input logic [NE*DW-1:0] b_pk,
                                          input logic c);
    logic [127:0] va;
    logic [127:0] vb;
    logic [127:0] prod;
    va = '0;
    vb = '0;
    for (int i = 0; i < NE; i++) begin
      va = va + (128'(a_pk[i*DW +: DW]) << (WL*i));
      vb = vb + (128'(b_pk[i*DW +: DW]) << (WL*i));
    end
    prod = va * vb;
    if (c) prod = prod >> (WL*NE);
    return prod[MW-1:0];
  endfunction

  function automatic logic [MW-1:0] out_value();
    logic [127:0] vo;
    vo = '0;
    for (int k = 0; k < NEO; k++) vo = vo + (128'(out_w[k]) << (WL*k));
    return vo[MW-1:0];
  endfunction

  // Bench-side view of the 2-cycle latency. It marks which cycles present a
  // transaction at the output.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= issued;
      v2 <= v1;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (rst_n && v2) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_underflow: got output 0x%012h with no expected entry", out_value());
      end else begin
        check("result", out_value(), sb_q.pop_front());
      end
    end
  end

  // Issue one transaction in the cycle after the next rising edge.
  task automatic drive(input logic [NE*DW-1:0] a_pk, input logic [NE*DW-1:0] b_pk, input logic c);
    @(posedge clk);
    #1;
    for (int i = 0; i < NE; i++) begin
      a_in[i] = a_pk[i*DW +: DW];
      b_in[i] = b_pk[i*DW +: DW];
    end
    ctl    = c;
    issued = 1'b1;
    sb_q.push_back(model(a_pk, b_pk, c));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      issued = 1'b0;
    end
  endtask

  function automatic logic [NE*DW-1:0] rand_op();
    logic [NE*DW-1:0] v;
    for (int i = 0; i < NE; i++) v[i*DW +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
    return v;
  endfunction

  logic [NE*DW-1:0] sa;
  logic [NE*DW-1:0] sb;
  logic [NE*DW-1:0] ones;
  logic [NE*DW-1:0] zeros;

  initial begin
    tests  = 0;
    fails  = 0;
    issued = 1'b0;
    ctl    = 1'b0;
    for (int i = 0; i < NE; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
    end
    rst_n = 1'b0;
    #12;
    check("reset_out", out_value(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // The low-half example is held for 10 cycles, then the high half of the
    // same operands.
    sa = {17'h00000, 17'h0FEEF, 17'h0FF0F};
    sb = {17'h00030, 17'h00000, 17'h0FFFF};
    for (int n = 0; n < 10; n++) drive(sa, sb, 1'b0);
    for (int n = 0; n < 10; n++) drive(sa, sb, 1'b1);
    idle(3);
    check("known_low",  model(sa, sb, 1'b0), 48'hD1BF_001F_00F1);
    check("known_high", model(sa, sb, 1'b1), 48'h0000_002F_CD00);

    // All-zero operands
    zeros = '0;
    drive(zeros, zeros, 1'b0);
    drive(zeros, zeros, 1'b1);

    // Words at their maximum redundant value
    ones = '1;
    for (int n = 0; n < 3; n++) drive(ones, ones, 1'b0);
    for (int n = 0; n < 3; n++) drive(ones, ones, 1'b1);
    drive(ones, zeros, 1'b1);

    // Back-to-back random transactions, with ctl alternating on every cycle
    for (int n = 0; n < 200; n++) drive(rand_op(), rand_op(), n[0]);
    idle(3);

    // Reset is asserted asynchronously between edges while traffic is flowing
    for (int n = 0; n < 5; n++) drive(rand_op(), rand_op(), n[0]);
    @(posedge clk);
    #3;
    rst_n  = 1'b0;
    issued = 1'b0;
    #1;
    check("async_reset_out", out_value(), '0);
    sb_q.delete();
    @(negedge clk);
    check("reset_hold_out", out_value(), '0);
    #2;
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) drive(rand_op(), rand_op(), n[0]);
    idle(4);

    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d entries left expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/half_multiply_core.md
HALF_MULTIPLY_CORE -- requirements
Module: half_multiply

Interface
REQ-001 The block SHALL have parameter NUM_ELEMENTS, default 3, giving the number of input words per operand.
REQ-002 The block SHALL have parameter DSP_BIT_LEN, default 17, giving the stored width of each input and output word (WORD_LEN+1).
REQ-003 The block SHALL have parameter WORD_LEN, default 16, giving the radix weight: word k has weight 2^(k*WORD_LEN).
REQ-004 The block SHALL have parameter NUM_ELEMENTS_OUT, default NUM_ELEMENTS, giving the number of output words.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-007 The block SHALL have port ctl, input, 1 bit, half select: 0 = low half, 1 = high half.
REQ-008 The block SHALL have port A, input, unpacked array [NUM_ELEMENTS] of DSP_BIT_LEN bits, operand A in redundant form.
REQ-009 The block SHALL have port B, input, unpacked array [NUM_ELEMENTS] of DSP_BIT_LEN bits, operand B in redundant form.
REQ-010 The block SHALL have port out, output, unpacked array [NUM_ELEMENTS_OUT] of DSP_BIT_LEN bits, the result in redundant form.

Function
REQ-011 Operand value SHALL be VA = sum A[i]*2^(i*WORD_LEN), using the full DSP_BIT_LEN bits of every word; VB is defined the same way.
REQ-012 Output value SHALL be VO = sum out[k]*2^(k*WORD_LEN); M = 2^(WORD_LEN*NUM_ELEMENTS_OUT).
REQ-013 With ctl=0, VO mod M SHALL equal (VA*VB) mod M.
- Only partial products with column i+j <= NUM_ELEMENTS_OUT-1 contribute.
REQ-014 With ctl=1, VO mod M SHALL equal floor(VA*VB / 2^(WORD_LEN*NUM_ELEMENTS)) mod M.
- All columns contribute, and carries from the low columns are propagated exactly.
REQ-015 Each out[k] SHALL be < 2^DSP_BIT_LEN, and the carry out of the top output word SHALL be discarded.
REQ-016 Column sums SHALL be accumulated at full width, at least 2*DSP_BIT_LEN + clog2(NUM_ELEMENTS)+1 bits, so no internal overflow occurs.
REQ-017 Column sums SHALL then be split into a low WORD_LEN-bit part plus a carry added into the next column.
REQ-018 Latency SHALL be exactly 2 clk cycles.
- A, B and ctl are registered on edge N.
- out is registered and valid after edge N+1.
REQ-019 The block SHALL be fully pipelined, accepting new A, B and ctl every cycle with no handshake or stall.
REQ-020 ctl SHALL travel with its operands through the pipeline, so that toggling ctl between consecutive cycles yields the correct per-transaction result.
REQ-021 Inputs held constant SHALL produce a constant out from the 2nd edge onward.
REQ-022 All-zero operands SHALL produce out words all 0 for either ctl value.

Reset
REQ-023 While rst_n=0, all pipeline registers SHALL clear asynchronously, with out words = 0 and the registered ctl = 0.
REQ-024 After rst_n deasserts, the first valid out SHALL appear 2 edges after the first sampled inputs.
REQ-025 Reset mid-operation SHALL discard all in-flight transactions.

Verification
REQ-026 Low-half scenario: A words {FF0F,FEEF,0000}, B words {FFFF,0000,0030}, ctl=0, hold 10 cycles -> VO mod 2^48 = 0xD1BF_001F_00F1.
REQ-027 High-half scenario: same operands, ctl=1, hold 10 cycles -> VO mod 2^48 = 0x0000_002F_CD00 (3132672).
- Full product is 0x2F_CD00_D1BF_001F_00F1.
REQ-028 Redundant-input scenario: all words 0x1FFFF on both operands, each ctl value -> results match REQ-013 and REQ-014 with no overflow.
REQ-029 Pipelining scenario: back-to-back random transactions with ctl alternating each cycle -> each out matches its transaction's model exactly 2 cycles later.
REQ-030 Reset scenario: assert rst_n=0 asynchronously between clock edges mid-stream -> out = 0 immediately; after release, correct results resume with 2-cycle latency.
